// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fighter_pkg
// Description : Shared types and constants for the fighter game-state
//               sequencer and the sprite/health-bar compositor.
// Revision    : 1.0 - initial release
// ============================================================================
package fighter_pkg;

    // Controller command codes as delivered on i_cmd.
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ATTACK = 3'd3,
        CMD_GUARD  = 3'd4
    } cmd_e;

    // Gesture codes consumed by the compositor.
    localparam logic [4:0] GEST_IDLE   = 5'd0;
    localparam logic [4:0] GEST_ATTACK = 5'd1;
    localparam logic [4:0] GEST_HURT   = 5'd2;

    // Sprite widths for each gesture, in pixels.
    localparam logic [9:0] c_SPRITE_W_IDLE   = 10'd125;
    localparam logic [9:0] c_SPRITE_W_ATTACK = 10'd150;
    localparam logic [9:0] c_SPRITE_W_HURT   = 10'd200;

    // Sequencer states with explicit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ATTACK = 2'd1,
        ST_HURT   = 2'd2,
        ST_KO     = 2'd3
    } state_e;

    // HURT and KO share the widest sprite.
    function automatic logic [4:0] gesture_of(input state_e s);
        case (s)
            ST_ATTACK: gesture_of = GEST_ATTACK;
            ST_HURT,
            ST_KO:     gesture_of = GEST_HURT;
            default:   gesture_of = GEST_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fighter_health.sv
`default_nettype none
// ============================================================================
// Module      : fighter_health
// Description : Saturating health register. On i_load the damage is
//               subtracted (floor at zero) and the sticky KO flag is updated.
//               o_zero_next tells the caller whether a load this cycle would
//               leave the player at zero health.
// Revision    : 1.0 - initial release
// ============================================================================
module fighter_health #(
    parameter logic [7:0] HEALTH_INIT = 8'd255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_damage,
    output logic [7:0] o_health,
    output logic       o_zero_next,
    output logic       o_ko
);

    logic [7:0] r_health;
    logic       r_ko;
    logic [8:0] w_diff;
    logic [7:0] w_health_next;

    // Bit 8 of the 9-bit difference is the borrow: damage >= health saturates to 0.
    always_comb begin
        w_diff        = {1'b0, r_health} - {1'b0, i_damage};
        w_health_next = (w_diff[8] || (w_diff[7:0] == 8'd0)) ? 8'd0 : w_diff[7:0];
    end

    assign o_zero_next = (w_health_next == 8'd0);

    // Health and KO only move when the sequencer commits a hit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_health <= HEALTH_INIT;
            r_ko     <= 1'b0;
        end else if (i_load) begin
            r_health <= w_health_next;
            r_ko     <= r_ko | o_zero_next;
        end
    end

    assign o_health = r_health;
    assign o_ko     = r_ko;

endmodule
`default_nettype wire

// File: rtl/fighter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fighter_ctrl
// Description : Per-player game-state sequencer. Commands and hits are
//               latched during the frame and acted on at i_frame_tick, so all
//               visible outputs change only once per frame.
//               Optional build macro: FIGHTER_GUARD_EN (GUARD halves damage
//               and suppresses the HURT state).
// Revision    : 1.0 - initial release
// ============================================================================
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter logic [9:0] X_INIT        = 10'd40,
    parameter logic [9:0] Y_INIT        = 10'd200,
    parameter logic [9:0] X_MIN         = 10'd0,
    parameter logic [9:0] X_MAX         = 10'd437,
    parameter logic [9:0] STEP          = 10'd8,
    parameter logic [7:0] ATTACK_FRAMES = 8'd12,
    parameter logic [7:0] HURT_FRAMES   = 8'd20,
    parameter logic [7:0] HEALTH_INIT   = 8'd255,
    parameter logic [7:0] DAMAGE        = 8'd20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_tick,
    input  logic       i_cmd_valid,
    input  logic [2:0] i_cmd,
    input  logic       i_hit,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic [4:0] o_gesture,
    output logic [7:0] o_health,
    output logic       o_ko,
    output logic       o_busy
);

    cmd_e       r_cmd_pend;
    logic       r_hit_pend;
    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [9:0] r_x;
    logic [9:0] w_x_next;
    logic [4:0] r_gesture;
    logic       r_busy;
    logic       w_apply_hit;
    logic       w_guard;
    logic [7:0] w_damage;
    logic       w_zero_next;
    logic [10:0] w_right_sum;
    logic [10:0] w_left_lim;
    logic [9:0]  w_x_right;
    logic [9:0]  w_x_left;

`ifdef FIGHTER_GUARD_EN
    assign w_guard = (r_state == ST_IDLE) && (r_cmd_pend == CMD_GUARD);
`else
    assign w_guard = 1'b0;
`endif

    assign w_damage = w_guard ? (DAMAGE >> 1) : DAMAGE;

    // Pending events: anything arriving on the tick cycle belongs to the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd_pend <= CMD_NONE;
            r_hit_pend <= 1'b0;
        end else if (i_frame_tick) begin
            r_cmd_pend <= i_cmd_valid ? cmd_e'(i_cmd) : CMD_NONE;
            r_hit_pend <= i_hit;
        end else begin
            if (i_cmd_valid) r_cmd_pend <= cmd_e'(i_cmd);
            if (i_hit)       r_hit_pend <= 1'b1;
        end
    end

    // Clamped horizontal moves using 11-bit intermediates to avoid wrap.
    always_comb begin
        w_right_sum = {1'b0, r_x} + {1'b0, STEP};
        w_left_lim  = {1'b0, X_MIN} + {1'b0, STEP};
        w_x_right   = (w_right_sum > {1'b0, X_MAX}) ? X_MAX : w_right_sum[9:0];
        w_x_left    = ({1'b0, r_x} < w_left_lim) ? X_MIN : (r_x - STEP);
    end

    // Next-state decision; only committed on the frame tick.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_x_next     = r_x;
        w_apply_hit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hit_pend) begin
                    w_apply_hit = 1'b1;
                    if (w_zero_next) begin
                        w_state_next = ST_KO;
                    end else if (!w_guard) begin
                        w_state_next = ST_HURT;
                        w_cnt_next   = HURT_FRAMES;
                    end
                end else if (r_cmd_pend == CMD_ATTACK) begin
                    w_state_next = ST_ATTACK;
                    w_cnt_next   = ATTACK_FRAMES;
                end else if (r_cmd_pend == CMD_LEFT) begin
                    w_x_next = w_x_left;
                end else if (r_cmd_pend == CMD_RIGHT) begin
                    w_x_next = w_x_right;
                end
            end
            ST_ATTACK: begin
                if (r_hit_pend) begin
                    w_apply_hit = 1'b1;
                    if (w_zero_next) begin
                        w_state_next = ST_KO;
                    end else begin
                        w_state_next = ST_HURT;
                        w_cnt_next   = HURT_FRAMES;
                    end
                end else if (r_cnt <= 8'd1) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            ST_HURT: begin
                if (r_cnt <= 8'd1) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: ;
        endcase
    end

    fighter_health #(
        .HEALTH_INIT(HEALTH_INIT)
    ) u_health (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (i_frame_tick && w_apply_hit),
        .i_damage    (w_damage),
        .o_health    (o_health),
        .o_zero_next (w_zero_next),
        .o_ko        (o_ko)
    );

    // State and visible sprite outputs update together once per frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_x       <= X_INIT;
            r_gesture <= GEST_IDLE;
            r_busy    <= 1'b0;
        end else if (i_frame_tick) begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_x       <= w_x_next;
            r_gesture <= gesture_of(w_state_next);
            r_busy    <= (w_state_next == ST_ATTACK) || (w_state_next == ST_HURT);
        end
    end

    assign o_x       = r_x;
    assign o_y       = Y_INIT;
    assign o_gesture = r_gesture;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fighter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fighter_ctrl
// Description : Self-checking bench for fighter_ctrl: a table of per-frame
//               vectors plus hand sequences for reset and tick-cycle events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fighter_ctrl;
    import fighter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       hit;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] gesture;
    logic [7:0] health;
    logic       ko;
    logic       busy;

    always #5 clk = ~clk;

    fighter_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frame_tick (tick),
        .i_cmd_valid  (cmd_valid),
        .i_cmd        (cmd),
        .i_hit        (hit),
        .o_x          (x),
        .o_y          (y),
        .o_gesture    (gesture),
        .o_health     (health),
        .o_ko         (ko),
        .o_busy       (busy)
    );

    typedef struct {
        logic       v;
        logic [2:0] c;
        int         hits;
        int         ex;
        int         eg;
        int         eh;
        int         eb;
        int         eko;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int eg, input int eh,
                           input int eb, input int eko);
        chk({tag, ".x"},       {22'd0, x},       ex);
        chk({tag, ".gesture"}, {27'd0, gesture}, eg);
        chk({tag, ".health"},  {24'd0, health},  eh);
        chk({tag, ".busy"},    {31'd0, busy},    eb);
        chk({tag, ".ko"},      {31'd0, ko},      eko);
    endtask

    task automatic add(input logic v, input logic [2:0] c, input int hits, input int ex,
                       input int eg, input int eh, input int eb, input int eko);
        vec_t r;
        r.v = v; r.c = c; r.hits = hits;
        r.ex = ex; r.eg = eg; r.eh = eh; r.eb = eb; r.eko = eko;
        tbl.push_back(r);
    endtask

    // One frame: optional command and up to two separate hit pulses, then a tick.
    task automatic do_frame(input logic v, input logic [2:0] c, input int hits);
        @(negedge clk); cmd_valid = v; cmd = c; hit = (hits > 0);
        @(negedge clk); cmd_valid = 1'b0; hit = 1'b0;
        @(negedge clk); hit = (hits > 1);
        @(negedge clk); hit = 1'b0; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int ex;
        int eh;
        rst = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; hit = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 40, 0, 255, 0, 0);
        chk("reset.y", {22'd0, y}, 200);
        rst = 1'b0;

        // ---- build the vector table ----
        ex = 40; eh = 255;
        for (int i = 0; i < 3; i++) add(1'b0, CMD_NONE, 0, ex, 0, eh, 0, 0);
        add(1'b1, CMD_RIGHT, 0, 48, 0, eh, 0, 0);
        add(1'b1, CMD_LEFT,  0, 40, 0, eh, 0, 0);
        // Attack: visible for 12 frames, a second ATTACK at frame 6 must not restart it.
        for (int k = 0; k <= 12; k++)
            add((k == 0 || k == 6), (k == 0 || k == 6) ? CMD_ATTACK : CMD_NONE, 0,
                ex, (k < 12) ? 1 : 0, eh, (k < 12) ? 1 : 0, 0);
        // Hit and ATTACK in the same frame: hit wins, 20 frames of HURT.
        eh = 235;
        add(1'b1, CMD_ATTACK, 1, ex, 2, eh, 1, 0);
        for (int k = 1; k <= 20; k++)
            add((k == 5), (k == 5) ? CMD_RIGHT : CMD_NONE, (k == 5) ? 1 : 0,
                ex, (k < 20) ? 2 : 0, eh, (k < 20) ? 1 : 0, 0);
        // RIGHT held 60 frames: clamps at 437 on the 50th.
        for (int k = 1; k <= 60; k++) begin
            ex = (ex + 8 > 437) ? 437 : ex + 8;
            add(1'b1, CMD_RIGHT, 0, ex, 0, eh, 0, 0);
        end
        // LEFT 54 frames down to 5, then 6 more clamp at 0.
        for (int k = 1; k <= 60; k++) begin
            ex = (ex < 8) ? 0 : ex - 8;
            add(1'b1, CMD_LEFT, 0, ex, 0, eh, 0, 0);
        end
        // Twelve more spaced hits (two pulses per frame count as one).
        for (int n = 1; n <= 12; n++) begin
            eh = (eh > 20) ? eh - 20 : 0;
            if (eh == 0) begin
                add(1'b0, CMD_NONE, 2, ex, 2, 0, 0, 1);
            end else begin
                add(1'b0, CMD_NONE, 2, ex, 2, eh, 1, 0);
                for (int k = 1; k <= 20; k++)
                    add(1'b0, CMD_NONE, 0, ex, (k < 20) ? 2 : 0, eh, (k < 20) ? 1 : 0, 0);
            end
        end
        // KO is terminal.
        add(1'b1, CMD_RIGHT,  0, ex, 2, 0, 0, 1);
        add(1'b1, CMD_ATTACK, 1, ex, 2, 0, 0, 1);
        add(1'b1, CMD_LEFT,   0, ex, 2, 0, 0, 1);

        // ---- apply the table ----
        foreach (tbl[i]) begin
            do_frame(tbl[i].v, tbl[i].c, tbl[i].hits);
            chk_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].eg, tbl[i].eh,
                    tbl[i].eb, tbl[i].eko);
        end

        // Asynchronous reset mid-frame: visible before any clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 40, 0, 255, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // GUARD plus a hit from IDLE.
        do_frame(1'b1, CMD_GUARD, 1);
`ifdef FIGHTER_GUARD_EN
        chk_all("guard_hit", 40, 0, 245, 0, 0);
`else
        chk_all("guard_hit", 40, 2, 235, 1, 0);
`endif

        do_reset();
        // Command on the tick cycle applies on the following tick.
        @(negedge clk); tick = 1'b1; cmd_valid = 1'b1; cmd = CMD_RIGHT;
        @(negedge clk); tick = 1'b0; cmd_valid = 1'b0;
        chk("cmd_on_tick.x", {22'd0, x}, 40);
        do_frame(1'b0, CMD_NONE, 0);
        chk("cmd_deferred.x", {22'd0, x}, 48);
        // No visible change mid-frame before the tick.
        @(negedge clk); cmd_valid = 1'b1; cmd = CMD_RIGHT;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midframe.x", {22'd0, x}, 48);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("after_tick.x", {22'd0, x}, 56);
        // Hit on the tick cycle applies on the following tick.
        @(negedge clk); tick = 1'b1; hit = 1'b1;
        @(negedge clk); tick = 1'b0; hit = 1'b0;
        chk("hit_on_tick.health", {24'd0, health}, 255);
        chk("hit_on_tick.gesture", {27'd0, gesture}, 0);
        do_frame(1'b0, CMD_NONE, 0);
        chk("hit_deferred.health", {24'd0, health}, 235);
        chk("hit_deferred.gesture", {27'd0, gesture}, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
